// File: rtl/chan_msg_arbiter.sv
// Purpose: round-robin owner of the shared inter-CPU message bus; grant -> one-cycle pulse -> ack wait, with optional bus hold.
// Latency: request seen in IDLE -> msg_pulse_o on the next clk_oe cycle; back-to-back via IDLE costs 3 cycles plus the ack wait.
// Backpressure: one transaction in flight; requesters stall until granted, dispatcher stalls the bus via disp_ack, TIMEOUT caps the stall.
module chan_msg_arbiter #(
   parameter int N_REQ   = 4,
   parameter int MSG_W   = 8,
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 32,
   parameter int TIMEOUT = 15
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      clk_oe,
   input  logic                      disp_online,
   input  logic                      disp_ack,
   input  logic [N_REQ-1:0]          req,
   input  logic [N_REQ-1:0]          lock,
   input  logic [N_REQ*MSG_W-1:0]    msg_i,
   input  logic [N_REQ*ADDR_W-1:0]   addr_i,
   input  logic [N_REQ*DATA_W-1:0]   data_i,
   output logic [N_REQ-1:0]          gnt,
   output logic [N_REQ-1:0]          done,
   output logic [MSG_W-1:0]          msg_o,
   output logic [ADDR_W-1:0]         addr_o,
   output logic [DATA_W-1:0]         data_o,
   output logic                      msg_pulse_o,
   output logic                      bus_busy,
   output logic                      err_timeout
);

   localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int TMR_W = 8;
   // Timer counts completed WAIT cycles; the transaction is abandoned at the
   // end of the TIMEOUT-th WAIT cycle without an ack.
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_REQ - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PULSE = 2'd1,
      WAIT  = 2'd2,
      HOLD  = 2'd3
   } state_t;

   state_t              state;
   state_t              state_n;

   logic [N_REQ-1:0]    gnt_n;
   logic [N_REQ-1:0]    done_n;
   logic                err_n;
   logic [IDX_W-1:0]    win_q;
   logic [IDX_W-1:0]    win_n;
   logic [IDX_W-1:0]    rr_ptr;
   logic [IDX_W-1:0]    rr_n;
   logic [TMR_W-1:0]    timer;
   logic [TMR_W-1:0]    timer_n;

   // Round-robin search result
   logic                rr_found;
   logic [IDX_W-1:0]    rr_win;
   logic [IDX_W-1:0]    cand;

   // Capture path: the requester whose inputs are latched at a decision point
   logic                cap_en;
   logic [IDX_W-1:0]    cap_sel;
   logic [MSG_W-1:0]    cap_msg;
   logic [ADDR_W-1:0]   cap_addr;
   logic [DATA_W-1:0]   cap_data;

   logic [MSG_W-1:0]    msg_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   data_q;

   // Round-robin pick: first requester above rr_ptr, wrapping modulo N_REQ.
   always_comb begin
      rr_found = 1'b0;
      rr_win   = '0;
      cand     = '0;
      for (int k = 1; k <= N_REQ; k++) begin
         cand = IDX_W'((int'(rr_ptr) + k) % N_REQ);
         if (!rr_found && req[cand]) begin
            rr_found = 1'b1;
            rr_win   = cand;
         end
      end
   end

   // Select the message fields of whichever requester is being captured.
   always_comb begin
      cap_msg  = '0;
      cap_addr = '0;
      cap_data = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (IDX_W'(i) == cap_sel) begin
            cap_msg  = msg_i[i*MSG_W +: MSG_W];
            cap_addr = addr_i[i*ADDR_W +: ADDR_W];
            cap_data = data_i[i*DATA_W +: DATA_W];
         end
      end
   end

   // Next-state logic: arbitration, ack/timeout handling and bus hold.
   always_comb begin
      state_n = state;
      gnt_n   = gnt;
      done_n  = '0;
      err_n   = 1'b0;
      win_n   = win_q;
      rr_n    = rr_ptr;
      timer_n = timer;
      cap_en  = 1'b0;
      cap_sel = rr_win;

      case (state)
         IDLE: begin
            if (disp_online && rr_found) begin
               win_n        = rr_win;
               gnt_n        = '0;
               gnt_n[rr_win] = 1'b1;
               cap_en       = 1'b1;
               cap_sel      = rr_win;
               state_n      = PULSE;
            end
         end

         PULSE: begin
            timer_n = '0;
            state_n = WAIT;
         end

         WAIT: begin
            // Ack takes priority over a timeout expiring in the same cycle.
            if (disp_ack) begin
               done_n[win_q] = 1'b1;
               if (lock[win_q] && disp_online) begin
                  state_n = HOLD;
               end else begin
                  rr_n    = win_q;
                  gnt_n   = '0;
                  state_n = IDLE;
               end
            end else if (timer == TMR_LAST) begin
               err_n   = 1'b1;
               rr_n    = win_q;
               gnt_n   = '0;
               state_n = IDLE;
            end else begin
               timer_n = timer + 1'b1;
            end
         end

         HOLD: begin
            // While done is still high the holder's req is stale; give it a
            // cycle to drop or refresh before treating it as a new beat.
            if (req[win_q] && !done[win_q]) begin
               cap_en  = 1'b1;
               cap_sel = win_q;
               state_n = PULSE;
            end else if (!lock[win_q] || !disp_online) begin
               rr_n    = win_q;
               gnt_n   = '0;
               state_n = IDLE;
            end
         end

         default: begin
            gnt_n   = '0;
            state_n = IDLE;
         end
      endcase
   end

   // Control registers: advance on clk_oe, pulses self-clear when clk_oe is low.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         gnt         <= '0;
         done        <= '0;
         err_timeout <= 1'b0;
         win_q       <= '0;
         rr_ptr      <= IDX_LAST;
         timer       <= '0;
      end else if (clk_oe) begin
         state       <= state_n;
         gnt         <= gnt_n;
         done        <= done_n;
         err_timeout <= err_n;
         win_q       <= win_n;
         rr_ptr      <= rr_n;
         timer       <= timer_n;
      end else begin
         done        <= '0;
         err_timeout <= 1'b0;
      end
   end

   // Capture registers: latched only at the IDLE/HOLD decision so later input
   // changes never leak onto the bus.
   always_ff @(posedge clk) begin
      if (rst) begin
         msg_q  <= '0;
         addr_q <= '0;
         data_q <= '0;
      end else if (clk_oe && cap_en) begin
         msg_q  <= cap_msg;
         addr_q <= cap_addr;
         data_q <= cap_data;
      end
   end

   // Bus drive: values appear only during the single PULSE cycle, zero otherwise.
   always_comb begin
      msg_pulse_o = (state == PULSE);
      bus_busy    = (state != IDLE);
      msg_o       = msg_pulse_o ? msg_q  : '0;
      addr_o      = msg_pulse_o ? addr_q : '0;
      data_o      = msg_pulse_o ? data_q : '0;
   end

endmodule

// File: tb/tb_chan_msg_arbiter.sv
// Directed bench for chan_msg_arbiter: reset, single transaction, round-robin,
// locked multi-beat hold, timeout, clk_oe gating and mid-transaction reset.
module tb_chan_msg_arbiter;

   localparam int N_REQ   = 4;
   localparam int MSG_W   = 8;
   localparam int DATA_W  = 32;
   localparam int ADDR_W  = 32;
   localparam int TIMEOUT = 15;

   logic                      clk;
   logic                      rst;
   logic                      clk_oe;
   logic                      disp_online;
   logic                      disp_ack;
   logic [N_REQ-1:0]          req;
   logic [N_REQ-1:0]          lock;
   logic [N_REQ*MSG_W-1:0]    msg_i;
   logic [N_REQ*ADDR_W-1:0]   addr_i;
   logic [N_REQ*DATA_W-1:0]   data_i;
   logic [N_REQ-1:0]          gnt;
   logic [N_REQ-1:0]          done;
   logic [MSG_W-1:0]          msg_o;
   logic [ADDR_W-1:0]         addr_o;
   logic [DATA_W-1:0]         data_o;
   logic                      msg_pulse_o;
   logic                      bus_busy;
   logic                      err_timeout;

   int n_assert = 0;
   int n_fail   = 0;

   chan_msg_arbiter #(
      .N_REQ   (N_REQ),
      .MSG_W   (MSG_W),
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .clk_oe      (clk_oe),
      .disp_online (disp_online),
      .disp_ack    (disp_ack),
      .req         (req),
      .lock        (lock),
      .msg_i       (msg_i),
      .addr_i      (addr_i),
      .data_i      (data_i),
      .gnt         (gnt),
      .done        (done),
      .msg_o       (msg_o),
      .addr_o      (addr_o),
      .data_o      (data_o),
      .msg_pulse_o (msg_pulse_o),
      .bus_busy    (bus_busy),
      .err_timeout (err_timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one clock and settle #1 past the edge before sampling/driving.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst         = 1'b1;
      clk_oe      = 1'b1;
      disp_online = 1'b0;
      disp_ack    = 1'b0;
      req         = '0;
      lock        = '0;
      msg_i       = '0;
      addr_i      = '0;
      data_i      = '0;
      tick();
      tick();

      // Reset state
      chk("rst_gnt",   64'(gnt), 64'h0);
      chk("rst_pulse", 64'(msg_pulse_o), 64'h0);
      chk("rst_busy",  64'(bus_busy), 64'h0);
      chk("rst_done",  64'(done), 64'h0);
      chk("rst_err",   64'(err_timeout), 64'h0);
      chk("rst_msg",   64'(msg_o), 64'h0);
      rst = 1'b0;

      // Single transaction from requester 0, ack two cycles after the pulse
      disp_online      = 1'b1;
      msg_i[7:0]       = 8'h21;
      addr_i[31:0]     = 32'h100;
      data_i[31:0]     = 32'h5;
      req              = 4'b0001;
      tick();
      chk("t1_gnt",   64'(gnt), 64'h1);
      chk("t1_pulse", 64'(msg_pulse_o), 64'h1);
      chk("t1_msg",   64'(msg_o), 64'h21);
      chk("t1_addr",  64'(addr_o), 64'h100);
      chk("t1_data",  64'(data_o), 64'h5);
      chk("t1_busy",  64'(bus_busy), 64'h1);
      tick();
      chk("t1_pulse_off", 64'(msg_pulse_o), 64'h0);
      chk("t1_msg_zero",  64'(msg_o), 64'h0);
      chk("t1_gnt_wait",  64'(gnt), 64'h1);
      tick();
      disp_ack = 1'b1;
      chk("t1_no_done_yet", 64'(done), 64'h0);
      tick();
      chk("t1_done",     64'(done), 64'h1);
      chk("t1_gnt_rel",  64'(gnt), 64'h0);
      chk("t1_busy_off", 64'(bus_busy), 64'h0);
      disp_ack = 1'b0;
      req      = '0;
      tick();
      chk("t1_done_clr", 64'(done), 64'h0);

      // Round-robin with all requesting and immediate acks: order 0,1,2,3,0
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
         msg_i[i*MSG_W +: MSG_W]    = 8'(8'h30 + i);
         addr_i[i*ADDR_W +: ADDR_W] = 32'(32'h1000 + i);
         data_i[i*DATA_W +: DATA_W] = 32'(32'hD0 + i);
      end
      req      = 4'b1111;
      disp_ack = 1'b1;
      for (int k = 0; k < 5; k++) begin
         int idx;
         idx = k % N_REQ;
         tick();
         chk("t2_gnt",   64'(gnt), 64'(1 << idx));
         chk("t2_pulse", 64'(msg_pulse_o), 64'h1);
         chk("t2_msg",   64'(msg_o), 64'(8'h30 + idx));
         chk("t2_addr",  64'(addr_o), 64'(32'h1000 + idx));
         tick();
         chk("t2_pulse_once", 64'(msg_pulse_o), 64'h0);
         chk("t2_gnt_wait",   64'(gnt), 64'(1 << idx));
         tick();
         chk("t2_done",    64'(done), 64'(1 << idx));
         chk("t2_gnt_rel", 64'(gnt), 64'h0);
      end
      req      = '0;
      disp_ack = 1'b0;
      tick();

      // Locked two-beat sequence from requester 1 while requester 2 waits
      msg_i[1*MSG_W +: MSG_W]    = 8'h01;
      addr_i[1*ADDR_W +: ADDR_W] = 32'hA0;
      data_i[1*DATA_W +: DATA_W] = 32'h11;
      msg_i[2*MSG_W +: MSG_W]    = 8'h33;
      req  = 4'b0110;
      lock = 4'b0010;
      tick();
      chk("t3_gnt_b1",  64'(gnt), 64'h2);
      chk("t3_pulse1",  64'(msg_pulse_o), 64'h1);
      chk("t3_msg1",    64'(msg_o), 64'h01);
      chk("t3_addr1",   64'(addr_o), 64'hA0);
      chk("t3_data1",   64'(data_o), 64'h11);
      msg_i[1*MSG_W +: MSG_W]    = 8'h02;
      addr_i[1*ADDR_W +: ADDR_W] = 32'hB0;
      data_i[1*DATA_W +: DATA_W] = 32'h22;
      tick();
      chk("t3_wait1", 64'(msg_pulse_o), 64'h0);
      disp_ack = 1'b1;
      tick();
      chk("t3_done1",     64'(done), 64'h2);
      chk("t3_gnt_hold",  64'(gnt), 64'h2);
      chk("t3_busy_hold", 64'(bus_busy), 64'h1);
      disp_ack = 1'b0;
      tick();
      chk("t3_req_ignored", 64'(msg_pulse_o), 64'h0);
      chk("t3_gnt_hold2",   64'(gnt), 64'h2);
      tick();
      chk("t3_pulse2", 64'(msg_pulse_o), 64'h1);
      chk("t3_msg2",   64'(msg_o), 64'h02);
      chk("t3_addr2",  64'(addr_o), 64'hB0);
      chk("t3_data2",  64'(data_o), 64'h22);
      chk("t3_gnt_b2", 64'(gnt), 64'h2);
      lock = '0;
      tick();
      disp_ack = 1'b1;
      req      = 4'b0100;
      tick();
      chk("t3_done2",   64'(done), 64'h2);
      chk("t3_gnt_rel", 64'(gnt), 64'h0);
      disp_ack = 1'b0;
      tick();
      chk("t3_gnt_r2", 64'(gnt), 64'h4);
      chk("t3_msg_r2", 64'(msg_o), 64'h33);
      tick();
      disp_ack = 1'b1;
      tick();
      chk("t3_done_r2", 64'(done), 64'h4);
      disp_ack = 1'b0;
      req      = '0;

      // Timeout: requester 3 never acked, requester 0 granted next
      msg_i[3*MSG_W +: MSG_W] = 8'h44;
      req = 4'b1001;
      tick();
      chk("t4_gnt",   64'(gnt), 64'h8);
      chk("t4_pulse", 64'(msg_pulse_o), 64'h1);
      chk("t4_msg",   64'(msg_o), 64'h44);
      req = 4'b0001;
      for (int j = 0; j < TIMEOUT; j++) begin
         tick();
         chk("t4_no_err",  64'(err_timeout), 64'h0);
         chk("t4_no_done", 64'(done), 64'h0);
         chk("t4_gnt_wait", 64'(gnt), 64'h8);
      end
      tick();
      chk("t4_err",      64'(err_timeout), 64'h1);
      chk("t4_gnt_rel",  64'(gnt), 64'h0);
      chk("t4_done_none", 64'(done), 64'h0);
      chk("t4_busy_off", 64'(bus_busy), 64'h0);
      tick();
      chk("t4_next_gnt", 64'(gnt), 64'h1);
      chk("t4_err_clr",  64'(err_timeout), 64'h0);
      chk("t4_next_pulse", 64'(msg_pulse_o), 64'h1);
      tick();
      disp_ack = 1'b1;
      tick();
      chk("t4_next_done", 64'(done), 64'h1);
      disp_ack = 1'b0;
      req      = '0;

      // clk_oe gating with the dispatcher offline
      disp_online = 1'b0;
      req         = 4'b0010;
      for (int i = 0; i < 6; i++) begin
         clk_oe = (i % 2 == 0);
         tick();
         chk("t5_offline_gnt", 64'(gnt), 64'h0);
      end
      clk_oe      = 1'b0;
      disp_online = 1'b1;
      tick();
      chk("t5_oe0_no_gnt", 64'(gnt), 64'h0);
      clk_oe = 1'b1;
      tick();
      chk("t5_gnt",   64'(gnt), 64'h2);
      chk("t5_pulse", 64'(msg_pulse_o), 64'h1);
      clk_oe = 1'b0;
      tick();
      chk("t5_pulse_held", 64'(msg_pulse_o), 64'h1);
      clk_oe = 1'b1;
      tick();
      chk("t5_wait", 64'(msg_pulse_o), 64'h0);
      disp_ack = 1'b1;
      req      = '0;
      tick();
      chk("t5_done", 64'(done), 64'h2);
      clk_oe   = 1'b0;
      disp_ack = 1'b0;
      tick();
      chk("t5_done_clr_oe0", 64'(done), 64'h0);
      clk_oe = 1'b1;

      // Reset during WAIT with lock set: bus released, pointer back to N_REQ-1
      req  = 4'b0100;
      lock = 4'b0100;
      tick();
      chk("t6_gnt", 64'(gnt), 64'h4);
      tick();
      rst = 1'b1;
      tick();
      chk("t6_rst_gnt",   64'(gnt), 64'h0);
      chk("t6_rst_pulse", 64'(msg_pulse_o), 64'h0);
      chk("t6_rst_busy",  64'(bus_busy), 64'h0);
      chk("t6_rst_msg",   64'(msg_o), 64'h0);
      rst  = 1'b0;
      req  = 4'b1111;
      lock = '0;
      tick();
      chk("t6_prio0_gnt",   64'(gnt), 64'h1);
      chk("t6_prio0_pulse", 64'(msg_pulse_o), 64'h1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
